// File: rtl/score_tracker_pkg.sv
// Shared game definitions: FSM encoding,
// seven-segment patterns and default tuning.
package score_tracker_pkg;

  typedef enum logic {
    ST_PLAYING = 1'b0,
    ST_ENDED   = 1'b1
  } state_e;

  localparam int DEF_LEVEL_STEP = 10;
  localparam int DEF_MAX_LEVEL  = 7;

  // Active-low segments, gfedcba order.
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'b1000000,
    7'b1111001,
    7'b0100100,
    7'b0110000,
    7'b0011001,
    7'b0010010,
    7'b0000010,
    7'b1111000,
    7'b0000000,
    7'b0010000
  };

endpackage

// File: rtl/bcd_seg_decoder.sv
// One BCD digit to active-low seven-segment.
// Non-decimal codes show blank.
module bcd_seg_decoder
  import score_tracker_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  // Pure lookup, blank for 10..15.
  always_comb begin
    seg_o = SEG_BLANK;
    case (bcd_i)
      4'd0:    seg_o = SEG_DIGIT[0];
      4'd1:    seg_o = SEG_DIGIT[1];
      4'd2:    seg_o = SEG_DIGIT[2];
      4'd3:    seg_o = SEG_DIGIT[3];
      4'd4:    seg_o = SEG_DIGIT[4];
      4'd5:    seg_o = SEG_DIGIT[5];
      4'd6:    seg_o = SEG_DIGIT[6];
      4'd7:    seg_o = SEG_DIGIT[7];
      4'd8:    seg_o = SEG_DIGIT[8];
      4'd9:    seg_o = SEG_DIGIT[9];
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/score_tracker.sv
// BCD score counter with speed level, session
// high score and seven-segment score display.
module score_tracker
  import score_tracker_pkg::*;
#(
  parameter int DIGITS     = 4,
  parameter int LEVEL_STEP = DEF_LEVEL_STEP,
  parameter int MAX_LEVEL  = DEF_MAX_LEVEL
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                point_tick,
  input  logic                game_over,
  input  logic                clear_score,
  output logic [4*DIGITS-1:0] score_bcd,
  output logic [4*DIGITS-1:0] high_bcd,
  output logic [2:0]          level,
  output logic                level_up,
  output logic                new_high,
  output logic [7*DIGITS-1:0] HEX_score
);

  localparam logic [7:0] STEP = 8'(LEVEL_STEP);
  localparam logic [2:0] LMAX = 3'(MAX_LEVEL);

  state_e              st_q, st_d;
  logic [4*DIGITS-1:0] score_q, score_d;
  logic [4*DIGITS-1:0] high_q, high_d;
  logic [4*DIGITS-1:0] inc_bcd;
  logic [2:0]          level_q, level_d;
  logic [7:0]          pts_q, pts_d;
  logic                lvup_q, lvup_d;
  logic                newhi_q, newhi_d;
  logic                tprev_q, gprev_q;
  logic                carry;
  logic                tick_rise, go_rise;

  assign tick_rise = point_tick & ~tprev_q;
  assign go_rise   = game_over & ~gprev_q;

  // BCD +1 with ripple carry; carry out means all-nines.
  always_comb begin
    carry   = 1'b1;
    inc_bcd = score_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (score_q[4*i +: 4] == 4'd9) begin
          inc_bcd[4*i +: 4] = 4'd0;
        end else begin
          inc_bcd[4*i +: 4] = score_q[4*i +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
    end
  end

  // Next state: clear > game end > counted tick.
  always_comb begin
    st_d    = st_q;
    score_d = score_q;
    high_d  = high_q;
    level_d = level_q;
    pts_d   = pts_q;
    lvup_d  = 1'b0;
    newhi_d = newhi_q;
    if (clear_score) begin
      st_d    = ST_PLAYING;
      score_d = '0;
      level_d = '0;
      pts_d   = '0;
      newhi_d = 1'b0;
    end else if (go_rise && st_q == ST_PLAYING) begin
      st_d = ST_ENDED;
      // Packed BCD compares like MSD-first digits.
      if (score_q > high_q) begin
        high_d  = score_q;
        newhi_d = 1'b1;
      end else begin
        newhi_d = 1'b0;
      end
    end else if (tick_rise && !game_over &&
                 st_q == ST_PLAYING && !carry) begin
      score_d = inc_bcd;
      if (pts_q + 8'd1 >= STEP) begin
        pts_d = '0;
        if (level_q < LMAX) begin
          level_d = level_q + 3'd1;
          lvup_d  = 1'b1;
        end
      end else begin
        pts_d = pts_q + 8'd1;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      st_q    <= ST_PLAYING;
      score_q <= '0;
      high_q  <= '0;
      level_q <= '0;
      pts_q   <= '0;
      lvup_q  <= 1'b0;
      newhi_q <= 1'b0;
      tprev_q <= 1'b0;
      gprev_q <= 1'b0;
    end else begin
      st_q    <= st_d;
      score_q <= score_d;
      high_q  <= high_d;
      level_q <= level_d;
      pts_q   <= pts_d;
      lvup_q  <= lvup_d;
      newhi_q <= newhi_d;
      tprev_q <= point_tick;
      gprev_q <= game_over;
    end
  end

  assign score_bcd = score_q;
  assign high_bcd  = high_q;
  assign level     = level_q;
  assign level_up  = lvup_q;
  assign new_high  = newhi_q;

  for (genvar g = 0; g < DIGITS; g++) begin : g_seg
    bcd_seg_decoder u_dec (
      .bcd_i (score_q[4*g +: 4]),
      .seg_o (HEX_score[7*g +: 7])
    );
  end

endmodule

// File: tb/tb_score_tracker.sv
// Directed bench for score_tracker with
// hand-computed expected values.
module tb_score_tracker;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        point_tick = 1'b0;
  logic        game_over = 1'b0;
  logic        clear_score = 1'b0;
  logic [15:0] score_bcd, high_bcd;
  logic [2:0]  level;
  logic        level_up, new_high;
  logic [27:0] HEX_score;

  int n_chk = 0;
  int n_pass = 0;
  int lu_cnt = 0;

  localparam logic [27:0] HEX_ZERO = {4{7'b1000000}};

  score_tracker dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .point_tick  (point_tick),
    .game_over   (game_over),
    .clear_score (clear_score),
    .score_bcd   (score_bcd),
    .high_bcd    (high_bcd),
    .level       (level),
    .level_up    (level_up),
    .new_high    (new_high),
    .HEX_score   (HEX_score)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h",
                  tag, got, exp);
  endtask

  // n clean pulses; counts level_up seen after each.
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge Clock) point_tick = 1'b1;
      @(negedge Clock) point_tick = 1'b0;
      if (level_up) lu_cnt++;
    end
  endtask

  task automatic do_reset();
    @(negedge Clock);
    Reset = 1'b1; game_over = 1'b0;
    point_tick = 1'b0; clear_score = 1'b0;
    @(negedge Clock);
    @(negedge Clock) Reset = 1'b0;
  endtask

  task automatic do_clear();
    @(negedge Clock);
    clear_score = 1'b1; game_over = 1'b0;
    @(negedge Clock) clear_score = 1'b0;
  endtask

  task automatic end_game();
    @(negedge Clock) game_over = 1'b1;
    @(negedge Clock);
  endtask

  initial begin
    do_reset();
    chk("rst_score", 32'(score_bcd), 32'h0);
    chk("rst_high", 32'(high_bcd), 32'h0);
    chk("rst_level", 32'(level), 32'h0);
    chk("rst_lvup", 32'(level_up), 32'h0);
    chk("rst_newhi", 32'(new_high), 32'h0);
    chk("rst_hex", 32'(HEX_score), 32'(HEX_ZERO));

    ticks(3);
    chk("t3_score", 32'(score_bcd), 32'h0003);
    chk("t3_level", 32'(level), 32'h0);
    chk("t3_hex", 32'(HEX_score),
        32'({7'b1000000, 7'b1000000,
             7'b1000000, 7'b0110000}));

    do_clear();
    chk("clr_score", 32'(score_bcd), 32'h0);
    lu_cnt = 0;
    ticks(9);
    chk("t9_lvup", lu_cnt, 0);
    ticks(1);
    chk("t10_score", 32'(score_bcd), 32'h0010);
    chk("t10_level", 32'(level), 32'h1);
    chk("t10_lvup_hi", 32'(level_up), 32'h1);
    @(negedge Clock);
    chk("t10_lvup_lo", 32'(level_up), 32'h0);

    lu_cnt = 0;
    ticks(60);
    chk("t70_score", 32'(score_bcd), 32'h0070);
    chk("t70_level", 32'(level), 32'h7);
    chk("t70_lvups", lu_cnt, 6);
    lu_cnt = 0;
    ticks(10);
    chk("t80_score", 32'(score_bcd), 32'h0080);
    chk("t80_level", 32'(level), 32'h7);
    chk("t80_lvups", lu_cnt, 0);

    @(negedge Clock) point_tick = 1'b1;
    repeat (20) @(negedge Clock);
    point_tick = 1'b0;
    @(negedge Clock);
    chk("held_score", 32'(score_bcd), 32'h0081);

    @(negedge Clock);
    game_over = 1'b1; point_tick = 1'b1;
    @(negedge Clock) point_tick = 1'b0;
    chk("gotick_score", 32'(score_bcd), 32'h0081);
    chk("gotick_high", 32'(high_bcd), 32'h0081);
    chk("gotick_newhi", 32'(new_high), 32'h1);

    do_reset();
    chk("rst2_high", 32'(high_bcd), 32'h0);

    ticks(42);
    end_game();
    chk("g1_high", 32'(high_bcd), 32'h0042);
    chk("g1_newhi", 32'(new_high), 32'h1);
    ticks(3);
    chk("g1_frozen", 32'(score_bcd), 32'h0042);
    do_clear();
    chk("g1c_score", 32'(score_bcd), 32'h0);
    chk("g1c_newhi", 32'(new_high), 32'h0);
    chk("g1c_level", 32'(level), 32'h0);
    chk("g1c_high", 32'(high_bcd), 32'h0042);

    ticks(42);
    end_game();
    chk("g2_newhi", 32'(new_high), 32'h0);
    chk("g2_high", 32'(high_bcd), 32'h0042);
    do_clear();

    ticks(107);
    chk("g3_score", 32'(score_bcd), 32'h0107);
    end_game();
    chk("g3_high", 32'(high_bcd), 32'h0107);
    chk("g3_newhi", 32'(new_high), 32'h1);
    do_clear();

    ticks(9999);
    chk("sat_score", 32'(score_bcd), 32'h9999);
    chk("sat_hex", 32'(HEX_score),
        32'({4{7'b0010000}}));
    ticks(1);
    chk("sat_hold", 32'(score_bcd), 32'h9999);
    chk("sat_level", 32'(level), 32'h7);

    do_reset();
    chk("mid_score", 32'(score_bcd), 32'h0);
    chk("mid_high", 32'(high_bcd), 32'h0);
    chk("mid_level", 32'(level), 32'h0);
    chk("mid_newhi", 32'(new_high), 32'h0);
    chk("mid_hex", 32'(HEX_score), 32'(HEX_ZERO));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/score_tracker.md
Name: score_tracker

Overview:
Downstream consumer of the lives/game-over handler's game_over and clear_score outputs. Counts points in BCD as obstacles are passed. Derives a speed level for the obstacle spawner, keeps a session high score, and drives seven-segment digits for the live score. Score is frozen while game_over is high and zeroed on clear_score.

Parameters:
DIGITS, 4, number of BCD score digits (score saturates at all-nines)
LEVEL_STEP, 10, points per speed-level increment (binary count, 1..255)
MAX_LEVEL, 7, highest speed level (fits in 3 bits)

Ports:
Clock  in  1  system clock
Reset  in  1  one clock; reset is synchronous and active-high
point_tick  in  1  obstacle-passed indication; level or pulse, rising edge counted
game_over  in  1  from lives handler; high = game ended
clear_score  in  1  from lives handler; 1-cycle restart pulse
score_bcd  out  4*DIGITS  current score, digit 0 in bits [3:0]
high_bcd  out  4*DIGITS  best score since Reset
level  out  3  current speed level, 0..MAX_LEVEL
level_up  out  1  1-cycle pulse when level increments
new_high  out  1  high when last ended game set a new high score
HEX_score  out  7*DIGITS  active-low segments, digit 0 in bits [6:0]

Behaviour:
- Reset (sampled high at an edge): score_bcd=0, high_bcd=0, level=0, level_up=0, new_high=0, point counter=0, tick_prev=0, go_prev=0, state=PLAYING. HEX_score shows all "0" (7'b1000000 per digit).
- Edge detect: tick_rise = point_tick & ~tick_prev. go_rise = game_over & ~go_prev. Both prev registers update every non-Reset cycle, including cycles where clear_score is high.
- FSM, two states: PLAYING and ENDED.
  - PLAYING -> ENDED on go_rise.
  - ENDED -> PLAYING on clear_score.
  - While game_over is high, behave as ENDED for counting: ticks are ignored.
- Scoring happens in PLAYING with game_over=0. On tick_rise, score +1 with BCD ripple carry (digit 9 -> 0, carry to next digit).
  - At all-nines (9999 for DIGITS=4) the score holds. No wrap, no level progress.
  - The new value is visible on score_bcd immediately after the edge where tick_rise is sampled (1-cycle latency).
- Level: a binary point counter increments with each counted tick. When it reaches LEVEL_STEP it resets to 0.
  - If level < MAX_LEVEL at that point: level +1 and level_up=1 for exactly one cycle.
  - At MAX_LEVEL: level holds and no pulse is generated.
- High score: on the PLAYING->ENDED transition, compare score_bcd to high_bcd (digit-lexicographic, MSD first).
  - If strictly greater: high_bcd <= score_bcd and new_high <= 1.
  - Otherwise new_high <= 0.
  - Equal scores do not set new_high.
- clear_score, in any state: score=0, level=0, point counter=0, level_up=0, new_high=0, state=PLAYING. high_bcd is preserved.
- Priority: Reset > clear_score > go_rise > tick_rise.
  - clear_score and tick_rise in the same cycle: tick is dropped.
  - go_rise and tick_rise in the same cycle: tick is dropped. The high-score compare uses the pre-tick score.
- A held point_tick counts once. Re-arming requires point_tick low for at least one cycle.
- HEX_score is combinational from score_bcd. Digit values 10-15 cannot occur; decode them to blank (7'b1111111).

Decomposition:
- Shared game package holds:
  - FSM state encoding (ST_PLAYING, ST_ENDED)
  - Segment constants SEG_BLANK and SEG_DIGIT[0..9]
  - Default LEVEL_STEP and MAX_LEVEL
- One sub-module, bcd_seg_decoder: 4-bit BCD in, 7-bit active-low segments out. Instantiate it DIGITS times in a generate loop.
- BCD increment and compare stay inline.

Test Plan:
- Reset high for 2 cycles, then 3 clean point_tick pulses -> score_bcd=16'h0003, level=0, HEX digit0=7'b0110000, higher digits 7'b1000000.
- 10 pulses with LEVEL_STEP=10 -> score 0x0010, level=1, level_up high for exactly one cycle after the 10th edge. Then 60 more pulses -> level=7 at point 70; pulse 80 gives no level_up and level stays 7.
- point_tick held high for 20 cycles -> score +1 only. Tick asserted in the same cycle as game_over rising -> not counted.
- Score 0x0042, then game_over rises -> high_bcd=0x0042, new_high=1, further ticks ignored. Then clear_score -> score 0, new_high=0, level 0, high_bcd still 0x0042.
- Second game ends at 0x0042 -> new_high=0, high_bcd unchanged. Third game ends at 0x0107 -> high_bcd=0x0107, new_high=1.
- Preload near saturation via 9999 ticks -> score 0x9999. Extra tick -> still 0x9999. Reset asserted mid-game -> all outputs zero, high_bcd=0.
